// File: rtl/check_level_pkg.sv
// Shared types and constants for the checker command path (check_level, wait_event, set_injector).
package tb_check_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StDecode,
    StCompare,
    StStable,
    StDone
  } t_chk_state;

  localparam string CmdChk       = "CHK";
  localparam string CmdChkStable = "CHK_STABLE";

  localparam int unsigned DefCntW = 16;

endpackage

// File: rtl/check_alias_lookup.sv
// Maps an alias name to the index of the first matching entry in an alias table.
module check_alias_lookup #(
  parameter int unsigned Size = 5,
  parameter int unsigned IdxW = 3
) (
  input  string            alias_names_i [Size],
  input  string            name_i,
  output logic [IdxW-1:0]  idx_o,
  output logic             found_o
);

  // Scan downwards so the lowest matching index wins.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int k = int'(Size) - 1; k >= 0; k--) begin
      if (alias_names_i[k] == name_i) begin
        idx_o   = IdxW'(k);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/check_level.sv
// Checker end of the command path: runs CHK / CHK_STABLE against named DUT outputs,
// pulses o_check_done per command and keeps saturating pass/fail counters.
module check_level
  import tb_check_pkg::*;
#(
  parameter int unsigned ARGS_NB     = 5,
  parameter int unsigned CHECK_SIZE  = 5,
  parameter int unsigned CHECK_WIDTH = 32,
  parameter int unsigned CNT_W       = DefCntW
) (
  input  logic                   clk,
  input  logic                   rst,
  input  string                  i_check_alias [CHECK_SIZE],
  input  logic                   i_sel_check,
  input  logic                   i_args_valid,
  input  string                  i_args [ARGS_NB],
  input  logic [CHECK_WIDTH-1:0] i_check [CHECK_SIZE],
  output logic                   o_check_done,
  output logic                   o_check_ok,
  output logic                   o_busy,
  output logic [CNT_W-1:0]       o_check_cnt,
  output logic [CNT_W-1:0]       o_err_cnt
);

  localparam int unsigned IdxW = (CHECK_SIZE > 1) ? $clog2(CHECK_SIZE) : 1;

  t_chk_state             state_q, state_d;
  string                  cmd_q, cmd_d;
  string                  alias_q, alias_d;
  string                  exp_str_q, exp_str_d;
  string                  cyc_str_q, cyc_str_d;
  logic [IdxW-1:0]        idx_q, idx_d;
  logic [CHECK_WIDTH-1:0] exp_q, exp_d;
  logic [31:0]            n_q, n_d;
  logic [31:0]            cnt_q, cnt_d;
  logic                   res_q, res_d;
  logic                   fin;
  int                     n_dec;

  logic                   done_q, ok_q;
  logic [CNT_W-1:0]       check_cnt_q, err_cnt_q;

  logic [IdxW-1:0]        lk_idx;
  logic                   lk_found;

  check_alias_lookup #(
    .Size (CHECK_SIZE),
    .IdxW (IdxW)
  ) u_lookup (
    .alias_names_i (i_check_alias),
    .name_i        (alias_q),
    .idx_o         (lk_idx),
    .found_o       (lk_found)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cmd_q     <= "";
      alias_q   <= "";
      exp_str_q <= "";
      cyc_str_q <= "";
      idx_q     <= '0;
      exp_q     <= '0;
      n_q       <= '0;
      cnt_q     <= '0;
      res_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      alias_q   <= alias_d;
      exp_str_q <= exp_str_d;
      cyc_str_q <= cyc_str_d;
      idx_q     <= idx_d;
      exp_q     <= exp_d;
      n_q       <= n_d;
      cnt_q     <= cnt_d;
      res_q     <= res_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    alias_d   = alias_q;
    exp_str_d = exp_str_q;
    cyc_str_d = cyc_str_q;
    idx_d     = idx_q;
    exp_d     = exp_q;
    n_d       = n_q;
    cnt_d     = cnt_q;
    res_d     = res_q;
    fin       = 1'b0;
    n_dec     = cyc_str_q.atoi();

    case (state_q)
      StIdle: begin
        if (i_args_valid && i_sel_check) begin
          cmd_d     = i_args[0];
          alias_d   = i_args[1];
          exp_str_d = i_args[2];
          cyc_str_d = i_args[3];
          state_d   = StDecode;
        end
      end
      StDecode: begin
        idx_d = lk_idx;
        exp_d = CHECK_WIDTH'($unsigned(exp_str_q.atohex()));
        n_d   = (n_dec <= 0) ? 32'd1 : 32'(n_dec);
        cnt_d = '0;
        res_d = 1'b0;
        if (!lk_found) begin
          state_d = StDone;
        end else if (cmd_q == CmdChk) begin
          state_d = StCompare;
        end else if (cmd_q == CmdChkStable) begin
          state_d = StStable;
        end else begin
          state_d = StDone;
        end
      end
      StCompare: begin
        res_d   = (i_check[idx_q] === exp_q);
        state_d = StDone;
      end
      StStable: begin
        // Any mismatch ends the window at once; otherwise count consecutive matches.
        if (i_check[idx_q] !== exp_q) begin
          res_d   = 1'b0;
          state_d = StDone;
        end else if (cnt_q + 32'd1 >= n_q) begin
          res_d   = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      StDone: begin
        fin     = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      done_q      <= 1'b0;
      ok_q        <= 1'b0;
      check_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      done_q <= fin;
      if (fin) begin
        ok_q <= res_q;
        if (check_cnt_q != '1) check_cnt_q <= check_cnt_q + 1'b1;
        if (!res_q && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + 1'b1;
      end
    end
  end

  assign o_check_done = done_q;
  assign o_check_ok   = ok_q;
  assign o_busy       = (state_q != StIdle);
  assign o_check_cnt  = check_cnt_q;
  assign o_err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_check_level.sv
// Directed bench for check_level: expected done pulses queued at issue time, checked on arrival.
module tb_check_level;

  localparam int unsigned ArgsNb     = 5;
  localparam int unsigned CheckSize  = 5;
  localparam int unsigned CheckWidth = 32;
  localparam int unsigned CntW       = 16;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  string                 alias_names [CheckSize];
  logic                  sel_check = 1'b0;
  logic                  args_valid = 1'b0;
  string                 args [ArgsNb];
  logic [CheckWidth-1:0] obs [CheckSize];
  logic                  check_done, check_ok, busy;
  logic [CntW-1:0]       check_cnt, err_cnt;

  check_level #(
    .ARGS_NB     (ArgsNb),
    .CHECK_SIZE  (CheckSize),
    .CHECK_WIDTH (CheckWidth),
    .CNT_W       (CntW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_check_alias (alias_names),
    .i_sel_check   (sel_check),
    .i_args_valid  (args_valid),
    .i_args        (args),
    .i_check       (obs),
    .o_check_done  (check_done),
    .o_check_ok    (check_ok),
    .o_busy        (busy),
    .o_check_cnt   (check_cnt),
    .o_err_cnt     (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit ok;
    int edge_at;
    int cc;
    int ec;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   mdl_cc   = 0;
  int   mdl_ec   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  // One clock: sample on the falling edge, consume any done pulse against the scoreboard.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (check_done) begin
      chk("done_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("done_cycle", cyc, e.edge_at);
        chk("done_ok", check_ok, e.ok);
        chk("done_check_cnt", check_cnt, e.cc);
        chk("done_err_cnt", err_cnt, e.ec);
      end
    end
  endtask

  task automatic issue(input string cmd, input string name, input string val, input string n,
                       output int t0);
    args[0]    = cmd;
    args[1]    = name;
    args[2]    = val;
    args[3]    = n;
    sel_check  = 1'b1;
    args_valid = 1'b1;
    tick();
    t0         = cyc;
    args_valid = 1'b0;
  endtask

  task automatic expect_done(input int t0, input int lat, input bit ok);
    exp_t e;
    mdl_cc++;
    if (!ok) mdl_ec++;
    e = '{ok: ok, edge_at: t0 + lat, cc: mdl_cc, ec: mdl_ec};
    sb.push_back(e);
  endtask

  task automatic drain(input int bound);
    int n = 0;
    while (sb.size() != 0 && n < bound) begin
      tick();
      n++;
    end
    chk("drain_pending", sb.size(), 0);
  endtask

  initial begin
    int t0;
    for (int k = 0; k < int'(CheckSize); k++) begin
      alias_names[k] = $sformatf("alias%0d", k);
      obs[k]         = CheckWidth'(32'h1000 + k);
    end
    for (int k = 0; k < int'(ArgsNb); k++) args[k] = "";

    // Reset, then idle
    tick();
    tick();
    rst = 1'b0;
    repeat (10) tick();
    chk("rst_done", check_done, 1'b0);
    chk("rst_ok", check_ok, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_check_cnt", check_cnt, 0);
    chk("rst_err_cnt", err_cnt, 0);

    // CHK pass
    obs[2] = 32'hCAFE;
    issue("CHK", "alias2", "CAFE", "0", t0);
    expect_done(t0, 3, 1'b1);
    chk("busy_after_accept", busy, 1'b1);
    drain(10);
    chk("busy_after_done", busy, 1'b0);

    // CHK wrong value, unknown alias, unknown command
    issue("CHK", "alias2", "BEEF", "1", t0);
    expect_done(t0, 3, 1'b0);
    drain(10);
    issue("CHK", "FOO", "CAFE", "1", t0);
    expect_done(t0, 2, 1'b0);
    drain(10);
    issue("CHX", "alias2", "CAFE", "1", t0);
    expect_done(t0, 2, 1'b0);
    drain(10);
    tick();
    chk("ok_held", check_ok, 1'b0);

    // CHK_STABLE N=4, value held
    obs[0] = 32'd5;
    issue("CHK_STABLE", "alias0", "5", "4", t0);
    expect_done(t0, 6, 1'b1);
    drain(20);

    // Same window with a glitch on the second compared cycle
    issue("CHK_STABLE", "alias0", "5", "4", t0);
    expect_done(t0, 4, 1'b0);
    tick();
    tick();
    obs[0] = 32'd4;
    tick();
    obs[0] = 32'd5;
    drain(20);

    // CHK_STABLE N=1 equals CHK latency
    issue("CHK_STABLE", "alias0", "5", "1", t0);
    expect_done(t0, 3, 1'b1);
    drain(10);

    // Second command while busy is dropped
    issue("CHK_STABLE", "alias0", "5", "10", t0);
    expect_done(t0, 12, 1'b1);
    repeat (3) tick();
    issue("CHK", "alias2", "BEEF", "1", t0);
    drain(30);
    repeat (5) tick();
    chk("cnt_after_ignored", check_cnt, mdl_cc);
    chk("err_after_ignored", err_cnt, mdl_ec);

    // args_valid without select is dropped
    args[0]    = "CHK";
    args[1]    = "alias2";
    args[2]    = "CAFE";
    args[3]    = "1";
    sel_check  = 1'b0;
    args_valid = 1'b1;
    tick();
    args_valid = 1'b0;
    chk("unsel_busy", busy, 1'b0);
    repeat (8) tick();
    chk("unsel_cnt", check_cnt, mdl_cc);

    // Reset in the middle of a stable window
    issue("CHK_STABLE", "alias0", "5", "10", t0);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst    = 1'b0;
    mdl_cc = 0;
    mdl_ec = 0;
    tick();
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_check_cnt", check_cnt, 0);
    chk("midrst_err_cnt", err_cnt, 0);
    chk("midrst_ok", check_ok, 1'b0);
    repeat (12) tick();
    issue("CHK", "alias2", "CAFE", "0", t0);
    expect_done(t0, 3, 1'b1);
    drain(10);
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
